me_ref_window_buf: RTL

//  - Parametrised reference-pixel window buffer feeding the ME SAD array.
//  - Accepts packed ref bytes from the fetch side through a valid/ready interface.
//  - Presents N_TAP consecutive pixels per cycle.
//  - Advances the window by a variable step.
//  - Replaces the fixed 23-tap, 4-bit, ber-selected ref read path with a synthesizable circular buffer.

---
 rtl/me_ref_window_buf.sv | 125 ++++++++++++
 1 files changed

// File: rtl/me_ref_window_buf.sv
// rtl/me_ref_window_buf.sv - circular reference-pixel window buffer feeding the ME SAD array
// Optional edge padding at end of row: define ME_REF_PAD_EN.
module me_ref_window_buf #(
    parameter int N_TAP    = 23,
    parameter int IN_BYTES = 2,
    parameter int DEPTH    = 64,
    parameter int PIX_W    = 4,
    parameter int MAX_STEP = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             ber,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [8*IN_BYTES-1:0]            in_data,
    input  logic                             eol,
    output logic                             out_valid,
    output logic [N_TAP*PIX_W-1:0]           out_pix,
    input  logic                             adv,
    input  logic [$clog2(MAX_STEP+1)-1:0]    adv_step,
    output logic [$clog2(DEPTH+1)-1:0]       level,
    output logic                             err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(MAX_STEP + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          win_full;
    logic          pad_active;
    logic [SW-1:0] step_cl;
    logic [LW-1:0] step_eff;
    logic [LW-1:0] level_nxt;

`ifdef ME_REF_PAD_EN
    logic eol_seen;

    assign pad_active = eol_seen && (level != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            eol_seen <= 1'b0;
        end else if (level_nxt == '0) begin
            eol_seen <= 1'b0;
        end else if (push && eol) begin
            eol_seen <= 1'b1;
        end
    end
`else
    logic unused_eol;

    assign unused_eol = eol;
    assign pad_active = 1'b0;
`endif

    assign win_full  = (level >= LW'(N_TAP));
    assign out_valid = !rst && (win_full || pad_active);
    // Ready looks only at the current level; a pop in the same cycle is not credited.
    assign in_ready  = !rst && !flush && (level <= LW'(DEPTH - IN_BYTES));
    assign push      = in_valid && in_ready;
    assign pop       = adv && out_valid && !flush;

    assign step_cl   = (adv_step > SW'(MAX_STEP)) ? SW'(MAX_STEP) : adv_step;
    // A padded window may hold fewer bytes than the requested step.
    assign step_eff  = (LW'(step_cl) > level) ? level : LW'(step_cl);
    assign level_nxt = level + (push ? LW'(IN_BYTES) : '0) - (pop ? step_eff : '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else begin
            level <= level_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(IN_BYTES);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(step_eff);
            end
            if (adv && !out_valid) begin
                err <= 1'b1;
            end
        end
    end

    // Earliest byte sits in the MSB lane of in_data.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int j = 0; j < IN_BYTES; j++) begin
                mem[wr_ptr + PW'(j)] <= in_data[8*(IN_BYTES-1-j) +: 8];
            end
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        logic [7:0]    b;
        logic [7:0]    sel;
        out_pix = '0;
        for (int k = 0; k < N_TAP; k++) begin
            idx = rd_ptr + PW'(k);
            if (pad_active && (LW'(k) >= level)) begin
                idx = rd_ptr + PW'(level - LW'(1));
            end
            b = mem[idx];
            if (PIX_W == 8) begin
                sel = b;
            end else begin
                sel = {4'h0, ber ? b[3:0] : b[7:4]};
            end
            if (out_valid) begin
                out_pix[k*PIX_W +: PIX_W] = sel[PIX_W-1:0];
            end
        end
    end

endmodule
